// File: rtl/snn_input_sequencer.sv
// Collects one SNN job (image, kernel and weight bytes) from a byte-wide host
// stream, then replays it as the fixed 72-cycle burst the SNN core expects.
module snn_input_sequencer #(
  parameter int IMG_LEN      = 72,
  parameter int KER_LEN      = 9,
  parameter int W_LEN        = 4,
  parameter int WAIT_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [1:0] s_type,
  input  logic [7:0] s_data,
  input  logic       snn_out_valid,
  output logic       in_valid,
  output logic [7:0] img,
  output logic [7:0] ker,
  output logic [7:0] weight,
  output logic       busy,
  output logic       job_done,
  output logic       err,
  output logic [1:0] dbg_state
);

  localparam int IMG_CW = $clog2(IMG_LEN + 1);
  localparam int KER_CW = $clog2(KER_LEN + 1);
  localparam int W_CW   = $clog2(W_LEN + 1);
  localparam int IMG_IW = $clog2(IMG_LEN);
  localparam int KER_IW = $clog2(KER_LEN);
  localparam int W_IW   = $clog2(W_LEN);
  localparam int WT_W   = $clog2(WAIT_TIMEOUT + 2);

  localparam logic [IMG_CW-1:0] IMG_MAX  = IMG_CW'(IMG_LEN);
  localparam logic [KER_CW-1:0] KER_MAX  = KER_CW'(KER_LEN);
  localparam logic [W_CW-1:0]   W_MAX    = W_CW'(W_LEN);
  localparam logic [IMG_IW-1:0] IDX_LAST = IMG_IW'(IMG_LEN - 1);
  localparam logic [IMG_IW-1:0] IDX_KER  = IMG_IW'(KER_LEN);
  localparam logic [IMG_IW-1:0] IDX_W    = IMG_IW'(W_LEN);
  localparam logic [WT_W-1:0]   WT_MAX   = WT_W'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t state, state_d;

  logic [7:0] img_buf [IMG_LEN];
  logic [7:0] ker_buf [KER_LEN];
  logic [7:0] w_buf   [W_LEN];

  logic [IMG_CW-1:0] img_cnt, img_cnt_inc;
  logic [KER_CW-1:0] ker_cnt, ker_cnt_inc;
  logic [W_CW-1:0]   w_cnt, w_cnt_inc;
  logic [IMG_IW-1:0] stream_idx;
  logic [WT_W-1:0]   wait_cnt;

  logic type_full, xfer, all_full_next;
  logic done_ok, timeout, clr_cnt, err_d;

  // Host handshake: a byte moves on a rising edge where s_valid && s_ready.
  // s_ready is a function of state, s_type and the fill counters only.
  always_comb begin
    type_full = 1'b0;
    case (s_type)
      2'd0:    type_full = (img_cnt == IMG_MAX);
      2'd1:    type_full = (ker_cnt == KER_MAX);
      2'd2:    type_full = (w_cnt == W_MAX);
      default: type_full = 1'b0;
    endcase
  end

  assign s_ready   = (state == ST_LOAD) && !type_full;
  assign xfer      = s_valid && s_ready;
  assign dbg_state = state;

  // Counter values including this cycle's transfer, so LOAD can leave on the
  // same edge that completes the job.
  always_comb begin
    img_cnt_inc = img_cnt;
    ker_cnt_inc = ker_cnt;
    w_cnt_inc   = w_cnt;
    if (xfer && s_type == 2'd0) img_cnt_inc = img_cnt + IMG_CW'(1);
    if (xfer && s_type == 2'd1) ker_cnt_inc = ker_cnt + KER_CW'(1);
    if (xfer && s_type == 2'd2) w_cnt_inc   = w_cnt + W_CW'(1);
    all_full_next = (img_cnt_inc == IMG_MAX) && (ker_cnt_inc == KER_MAX) &&
                    (w_cnt_inc == W_MAX);
  end

  always_comb begin
    state_d = state;
    done_ok = 1'b0;
    timeout = 1'b0;
    case (state)
      ST_LOAD: begin
        if (all_full_next) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (stream_idx == IDX_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A response on the final counted cycle still wins over the timeout.
        if (snn_out_valid) begin
          state_d = ST_LOAD;
          done_ok = 1'b1;
        end else if (wait_cnt == WT_MAX) begin
          state_d = ST_LOAD;
          timeout = 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    clr_cnt = done_ok || timeout;
    err_d   = (xfer && s_type == 2'd3) ||
              (snn_out_valid && state != ST_WAIT) ||
              timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_cnt    <= '0;
      ker_cnt    <= '0;
      w_cnt      <= '0;
      stream_idx <= '0;
      wait_cnt   <= '0;
    end else begin
      if (clr_cnt) begin
        img_cnt <= '0;
        ker_cnt <= '0;
        w_cnt   <= '0;
      end else begin
        img_cnt <= img_cnt_inc;
        ker_cnt <= ker_cnt_inc;
        w_cnt   <= w_cnt_inc;
      end
      if (state == ST_STREAM && stream_idx != IDX_LAST) stream_idx <= stream_idx + IMG_IW'(1);
      else                                             stream_idx <= '0;
      if (state == ST_WAIT && state_d == ST_WAIT) wait_cnt <= wait_cnt + WT_W'(1);
      else                                       wait_cnt <= '0;
    end
  end

  // Operand storage needs no reset; it is always refilled before being read.
  always_ff @(posedge clk) begin
    if (xfer) begin
      case (s_type)
        2'd0:    img_buf[img_cnt[IMG_IW-1:0]] <= s_data;
        2'd1:    ker_buf[ker_cnt[KER_IW-1:0]] <= s_data;
        2'd2:    w_buf[w_cnt[W_IW-1:0]]       <= s_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid <= 1'b0;
      img      <= '0;
      ker      <= '0;
      weight   <= '0;
      busy     <= 1'b0;
      job_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      in_valid <= (state == ST_STREAM);
      img      <= '0;
      ker      <= '0;
      weight   <= '0;
      if (state == ST_STREAM) begin
        img <= img_buf[stream_idx];
        if (stream_idx < IDX_KER) ker    <= ker_buf[stream_idx[KER_IW-1:0]];
        if (stream_idx < IDX_W)   weight <= w_buf[stream_idx[W_IW-1:0]];
      end
      busy     <= (state_d != ST_LOAD);
      job_done <= done_ok;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_snn_input_sequencer.sv
// Randomized bench for snn_input_sequencer: jobs are built as byte arrays and
// the expected 72-beat burst is derived from them and queued per beat.
module tb_snn_input_sequencer;
  localparam int IMG_LEN = 72;
  localparam int KER_LEN = 9;
  localparam int W_LEN   = 4;

  logic       clk, rst_n;
  logic       s_valid, s_ready;
  logic [1:0] s_type;
  logic [7:0] s_data;
  logic       snn_out_valid;
  logic       in_valid, busy, job_done, err;
  logic [7:0] img, ker, weight;
  logic [1:0] dbg_state;

  snn_input_sequencer dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_type(s_type), .s_data(s_data), .snn_out_valid(snn_out_valid),
    .in_valid(in_valid), .img(img), .ker(ker), .weight(weight),
    .busy(busy), .job_done(job_done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] exp_q[$];
  int          run_len = 0;
  int unsigned start_t, exp_start, hs_time;
  logic [7:0]  j_img [IMG_LEN];
  logic [7:0]  j_ker [KER_LEN];
  logic [7:0]  j_w   [W_LEN];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every beat of every burst against the queued expectation
  always @(negedge clk) begin
    logic [23:0] e;
    if (in_valid) begin
      if (run_len == 0) start_t = $time;
      run_len++;
      check("busy_in_burst", 32'(busy), 32'd1);
      if (exp_q.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("beat", {8'h0, img, ker, weight}, {8'h0, e});
      end
    end else if (run_len != 0) begin
      check("burst_len", run_len, IMG_LEN);
      check("burst_start", start_t, exp_start);
      run_len = 0;
    end
  end

  // driver tasks (called right after a falling edge, return after one)
  task automatic send_byte(input logic [1:0] t, input logic [7:0] d, input int gap);
    int  tries = 0;
    bit  ok;
    for (int i = 0; i < gap; i++) @(negedge clk);
    s_valid = 1'b1; s_type = t; s_data = d;
    while (1) begin
      #4 ok = s_ready;
      @(posedge clk);
      if (ok) break;
      tries++;
      if (tries > 300) begin check("hs_timeout", 32'd0, 32'd1); break; end
      @(negedge clk);
    end
    hs_time = $time;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic probe_ready(input string tag, input logic [1:0] t, input logic exp);
    s_valid = 1'b0; s_type = t;
    #4 check(tag, 32'(s_ready), 32'(exp));
    @(negedge clk);
  endtask

  task automatic random_job();
    foreach (j_img[i]) j_img[i] = 8'($urandom_range(0, 255));
    foreach (j_ker[i]) j_ker[i] = 8'($urandom_range(0, 255));
    foreach (j_w[i])   j_w[i]   = 8'($urandom_range(0, 255));
  endtask

  // reference: beat k carries img[k], ker[k] for k<9, weight[k] for k<4
  task automatic push_expected();
    for (int k = 0; k < IMG_LEN; k++)
      exp_q.push_back({j_img[k], (k < KER_LEN) ? j_ker[k] : 8'h00, (k < W_LEN) ? j_w[k] : 8'h00});
    exp_start = hs_time + 15;
  endtask

  task automatic load_interleaved(input int max_gap);
    int ni = 0, nk = 0, nw = 0, r;
    while (ni < IMG_LEN || nk < KER_LEN || nw < W_LEN) begin
      r = $urandom_range(0, 2);
      if (r == 0 && ni < IMG_LEN) begin send_byte(2'd0, j_img[ni], $urandom_range(0, max_gap)); ni++; end
      else if (r == 1 && nk < KER_LEN) begin send_byte(2'd1, j_ker[nk], $urandom_range(0, max_gap)); nk++; end
      else if (r == 2 && nw < W_LEN) begin send_byte(2'd2, j_w[nw], $urandom_range(0, max_gap)); nw++; end
    end
    push_expected();
  endtask

  task automatic wait_burst_end();
    int n = 0;
    while (!in_valid && n < 400) begin @(negedge clk); n++; end
    while (in_valid && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) check("burst_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_job(input int delay);
    for (int i = 0; i < delay; i++) @(negedge clk);
    snn_out_valid = 1'b1;
    @(negedge clk);
    snn_out_valid = 1'b0;
    check("job_done", 32'(job_done), 32'd1);
    check("no_err_on_done", 32'(err), 32'd0);
    check("state_load", 32'(dbg_state), 32'd0);
    probe_ready("ready_after_done", 2'd0, 1'b1);
    check("job_done_pulse", 32'(job_done), 32'd0);
  endtask

  logic [7:0] extra_byte;

  initial begin
    int i;
    rst_n = 1'b0; s_valid = 1'b0; s_type = 2'd0; s_data = 8'h00; snn_out_valid = 1'b0;
    #23;
    check("rst_in_valid", 32'(in_valid), 32'd0);
    check("rst_outputs", {8'h0, img, ker, weight}, 32'd0);
    check("rst_flags", {29'h0, busy, job_done, err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    probe_ready("rst_ready", 2'd0, 1'b1);

    // type-ordered job with the fixed reference data
    for (int k = 0; k < IMG_LEN; k++) j_img[k] = 8'(k);
    for (int k = 0; k < KER_LEN; k++) j_ker[k] = 8'(k + 1);
    for (int k = 0; k < W_LEN; k++)   j_w[k]   = 8'(k + 10);
    for (int k = 0; k < KER_LEN; k++) send_byte(2'd1, j_ker[k], 0);
    probe_ready("ker_full_ready", 2'd1, 1'b0);
    for (int k = 0; k < W_LEN; k++) send_byte(2'd2, j_w[k], 0);
    probe_ready("w_full_ready", 2'd2, 1'b0);
    probe_ready("img_open_ready", 2'd0, 1'b1);
    for (int k = 0; k < IMG_LEN; k++) send_byte(2'd0, j_img[k], 0);
    push_expected();
    wait_burst_end();
    check("busy_in_wait", 32'(busy), 32'd1);
    finish_job(10);

    // random interleaved jobs; the last answers on the final counted cycle
    for (int j = 0; j < 3; j++) begin
      random_job();
      load_interleaved(3);
      wait_burst_end();
      finish_job((j == 2) ? 31 : $urandom_range(0, 20));
    end

    // no response: timeout recovery
    random_job();
    load_interleaved(1);
    wait_burst_end();
    i = 0;
    while (i < 40) begin
      @(negedge clk); i++;
      if (err) break;
    end
    check("timeout_cycles", i, 32'd32);
    check("timeout_no_done", 32'(job_done), 32'd0);
    check("timeout_state", 32'(dbg_state), 32'd0);
    probe_ready("timeout_ready_img", 2'd0, 1'b1);
    check("timeout_err_pulse", 32'(err), 32'd0);
    probe_ready("timeout_ready_ker", 2'd1, 1'b1);
    probe_ready("timeout_ready_w", 2'd2, 1'b1);

    // reserved byte, stray response and an overfill attempt
    random_job();
    for (int k = 0; k < 40; k++) send_byte(2'd0, j_img[k], 0);
    snn_out_valid = 1'b1;
    send_byte(2'd3, 8'hA5, 0);
    snn_out_valid = 1'b0;
    check("err_type3", 32'(err), 32'd1);
    @(negedge clk);
    check("err_single_pulse", 32'(err), 32'd0);
    for (int k = 40; k < IMG_LEN; k++) send_byte(2'd0, j_img[k], $urandom_range(0, 1));
    extra_byte = 8'($urandom_range(0, 255));
    s_valid = 1'b1; s_type = 2'd0; s_data = extra_byte;
    for (int k = 0; k < 4; k++) begin
      #4 check("img_overfill_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
    end
    s_valid = 1'b0;
    for (int k = 0; k < KER_LEN; k++) send_byte(2'd1, j_ker[k], 0);
    for (int k = 0; k < W_LEN; k++)   send_byte(2'd2, j_w[k], 0);
    push_expected();
    wait_burst_end();
    finish_job(5);
    random_job();
    j_img[0] = extra_byte;
    send_byte(2'd0, extra_byte, 0);
    for (int k = 1; k < IMG_LEN; k++) send_byte(2'd0, j_img[k], 0);
    for (int k = 0; k < KER_LEN; k++) send_byte(2'd1, j_ker[k], 0);
    for (int k = 0; k < W_LEN; k++)   send_byte(2'd2, j_w[k], 0);
    push_expected();
    wait_burst_end();
    finish_job(2);

    // reset in the middle of a burst
    random_job();
    load_interleaved(0);
    i = 0;
    while (!in_valid && i < 100) begin @(negedge clk); i++; end
    check("abort_burst_seen", 32'(in_valid), 32'd1);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    run_len = 0;
    exp_q.delete();
    #1;
    check("abort_in_valid", 32'(in_valid), 32'd0);
    check("abort_outputs", {8'h0, img, ker, weight}, 32'd0);
    check("abort_flags", {28'h0, busy, job_done, err, 1'b0}, 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    random_job();
    load_interleaved(2);
    wait_burst_end();
    finish_job(7);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
